// File: rtl/wb_pkg.sv
// Shared types for the register-bank write-back slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    // One buffered memory result waiting for the write port.
    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Owner of the write port for the current cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ALU  = 2'd1,
        MEM  = 2'd2
    } wb_src_e;

endpackage

// File: rtl/regfile_writeback_if.sv
// Bundle of the ALU, memory, issue/query and register-bank write signals.
// Latency: n/a (wiring only).
// Backpressure: memory path via mem_valid/mem_ready; ALU and issue paths never stall.
// Ports: master drives results, issue marks and queries; slave (write-back block)
// returns mem_ready, pending hits, the bank write port and, with WB_BYPASS_EN,
// the forwarding outputs.
interface regfile_writeback_if #(
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int ADDR_W = wb_pkg::ADDR_W
);
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_rd;
    logic [ADDR_W-1:0] pend_query_1;
    logic [ADDR_W-1:0] pend_query_2;
    logic              pend_hit_1;
    logic              pend_hit_2;
    logic              reg_write;
    logic [ADDR_W-1:0] write_register;
    logic [DATA_W-1:0] write_data;
`ifdef WB_BYPASS_EN
    logic              fwd_valid_1;
    logic              fwd_valid_2;
    logic [DATA_W-1:0] fwd_data_1;
    logic [DATA_W-1:0] fwd_data_2;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output iss_valid, iss_rd, pend_query_1, pend_query_2,
        input  mem_ready, pend_hit_1, pend_hit_2, reg_write, write_register, write_data,
        input  fwd_valid_1, fwd_valid_2, fwd_data_1, fwd_data_2
    );
    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  iss_valid, iss_rd, pend_query_1, pend_query_2,
        output mem_ready, pend_hit_1, pend_hit_2, reg_write, write_register, write_data,
        output fwd_valid_1, fwd_valid_2, fwd_data_1, fwd_data_2
    );
`else
    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output iss_valid, iss_rd, pend_query_1, pend_query_2,
        input  mem_ready, pend_hit_1, pend_hit_2, reg_write, write_register, write_data
    );
    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  iss_valid, iss_rd, pend_query_1, pend_query_2,
        output mem_ready, pend_hit_1, pend_hit_2, reg_write, write_register, write_data
    );
`endif
endinterface

// File: rtl/wb_fifo.sv
// Circular FIFO of pending memory write-back entries.
// Latency: a push is visible at head the cycle after it is written.
// Backpressure: full is taken from registered occupancy; a push while full is ignored.
// Ports: push/push_entry write, pop or drop (pop without use) advance the head,
// full/empty/head report state.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    input  logic      drop,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        slots [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = (pop || drop) && !empty;
    assign head    = slots[rd_ptr];

    // Storage carries no reset: stale slots are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= push_entry;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Arbitrates ALU and buffered memory results onto the single register-bank write port and tracks pending destinations.
// Latency: ALU result -> bank write 1 cycle; memory result -> bank write 2 cycles when the port is free.
// Backpressure: ALU path never stalls (fixed priority); memory path held off by mem_ready when the FIFO is full.
// Ports: clk, rst_n (async active-low), bus (slave modport). Defining WB_BYPASS_EN adds
// fwd_valid_1/2 and fwd_data_1/2 covering the bank's same-cycle write/read window.
module regfile_writeback #(
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int ADDR_W = wb_pkg::ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_writeback_if.slave   bus
);
    import wb_pkg::*;

    localparam int NREG = 1 << ADDR_W;

    wb_entry_t         head;
    wb_entry_t         push_entry;
    logic              fifo_full;
    logic              fifo_empty;
    logic              mem_push;
    logic              mem_pop;
    logic              head_drop;
    wb_src_e           src;
    logic [ADDR_W-1:0] win_rd;
    logic [DATA_W-1:0] win_data;
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pending_nxt;
    logic              reg_write_q;
    logic [ADDR_W-1:0] write_register_q;
    logic [DATA_W-1:0] write_data_q;

    // mem_ready is registered occupancy only: a same-cycle pop never frees a full FIFO.
    assign bus.mem_ready = !fifo_full;
    assign mem_push      = bus.mem_valid && !fifo_full;
    assign push_entry    = '{rd: bus.mem_rd, data: bus.mem_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (mem_push),
        .push_entry (push_entry),
        .pop        (mem_pop),
        .drop       (head_drop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (head)
    );

    // Fixed-priority grant. A queued result aimed at the same register the ALU is
    // writing now is already stale, so it is discarded instead of written later.
    always_comb begin
        src       = IDLE;
        win_rd    = '0;
        win_data  = '0;
        mem_pop   = 1'b0;
        head_drop = 1'b0;
        if (bus.alu_valid) begin
            src       = ALU;
            win_rd    = bus.alu_rd;
            win_data  = bus.alu_data;
            head_drop = !fifo_empty && (head.rd == bus.alu_rd) && (bus.alu_rd != '0);
        end else if (!fifo_empty) begin
            src      = MEM;
            win_rd   = head.rd;
            win_data = head.data;
            mem_pop  = 1'b1;
        end
    end

    // Clear first, then set, so a re-issue to a retiring register stays pending.
    always_comb begin
        pending_nxt = pending;
        if (mem_pop || head_drop) begin
            pending_nxt[head.rd] = 1'b0;
        end
        if (bus.iss_valid && (bus.iss_rd != '0)) begin
            pending_nxt[bus.iss_rd] = 1'b1;
        end
    end

    // Grants to register 0 still consume the slot but never raise the write enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending          <= '0;
            reg_write_q      <= 1'b0;
            write_register_q <= '0;
            write_data_q     <= '0;
        end else begin
            pending     <= pending_nxt;
            reg_write_q <= (src != IDLE) && (win_rd != '0);
            if (src != IDLE) begin
                write_register_q <= win_rd;
                write_data_q     <= win_data;
            end
        end
    end

    assign bus.reg_write      = reg_write_q;
    assign bus.write_register = write_register_q;
    assign bus.write_data     = write_data_q;

    assign bus.pend_hit_1 = (bus.pend_query_1 != '0) && pending[bus.pend_query_1];
    assign bus.pend_hit_2 = (bus.pend_query_2 != '0) && pending[bus.pend_query_2];

`ifdef WB_BYPASS_EN
    assign bus.fwd_valid_1 = reg_write_q && (write_register_q == bus.pend_query_1)
                             && (bus.pend_query_1 != '0);
    assign bus.fwd_valid_2 = reg_write_q && (write_register_q == bus.pend_query_2)
                             && (bus.pend_query_2 != '0);
    assign bus.fwd_data_1  = write_data_q;
    assign bus.fwd_data_2  = write_data_q;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: ALU vector table plus hand-written multi-cycle sequences.
// Every bank write is matched against a queue of expected writes filled at drive time.
// Build with WB_BYPASS_EN defined to also exercise the forwarding outputs.
module tb_regfile_writeback;
    import wb_pkg::*;

    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    regfile_writeback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    wb_entry_t exp_q[$];
    wb_entry_t mem_exp[$];
    wb_entry_t sb_e;

    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
        logic              exp_write;
    } alu_vec_t;

    alu_vec_t vecs[4];

    function automatic wb_entry_t mk(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] data);
        wb_entry_t e;
        e.rd   = rd;
        e.data = data;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.alu_valid    = 1'b0;
        bus.alu_rd       = '0;
        bus.alu_data     = '0;
        bus.mem_valid    = 1'b0;
        bus.mem_rd       = '0;
        bus.mem_data     = '0;
        bus.iss_valid    = 1'b0;
        bus.iss_rd       = '0;
        bus.pend_query_1 = '0;
        bus.pend_query_2 = '0;
    endtask

    // Scoreboard: every write the bank sees must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && bus.reg_write) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_write: got rd=%0d data=0x%0h, required no write",
                         bus.write_register, bus.write_data);
            end else begin
                sb_e = exp_q.pop_front();
                if (bus.write_register !== sb_e.rd || bus.write_data !== sb_e.data) begin
                    errors++;
                    $display("FAIL sb_write: got rd=%0d data=0x%0h, required rd=%0d data=0x%0h",
                             bus.write_register, bus.write_data, sb_e.rd, sb_e.data);
                end
            end
        end
    end

    initial begin
        vecs[0] = '{5'd3,  32'hDEADBEEF, 1'b1};
        vecs[1] = '{5'd31, 32'h12345678, 1'b1};
        vecs[2] = '{5'd0,  32'hCAFEF00D, 1'b0};
        vecs[3] = '{5'd1,  32'h00000000, 1'b1};

        drive_idle();
        #1 rst_n = 1'b0;
        #2;
        chk("rst_reg_write", bus.reg_write, 0);
        chk("rst_write_register", bus.write_register, 0);
        chk("rst_write_data", bus.write_data, 0);
        chk("rst_mem_ready", bus.mem_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ALU-only vectors: write visible exactly one cycle after the result.
        for (int i = 0; i < 4; i++) begin
            bus.alu_valid = 1'b1;
            bus.alu_rd    = vecs[i].rd;
            bus.alu_data  = vecs[i].data;
            if (vecs[i].exp_write) exp_q.push_back(mk(vecs[i].rd, vecs[i].data));
            step();
            chk($sformatf("alu%0d_reg_write", i), bus.reg_write, vecs[i].exp_write);
            if (vecs[i].exp_write) begin
                chk($sformatf("alu%0d_write_register", i), bus.write_register, vecs[i].rd);
                chk($sformatf("alu%0d_write_data", i), bus.write_data, vecs[i].data);
            end
            bus.alu_valid = 1'b0;
            step();
            chk($sformatf("alu%0d_single_cycle", i), bus.reg_write, 0);
        end

        // Memory retire clears the pending bit in the write edge.
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd7;
        step();
        bus.iss_valid    = 1'b0;
        bus.pend_query_1 = 5'd7;
        #1;
        chk("mem_pend_set", bus.pend_hit_1, 1);
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd7;
        bus.mem_data  = 32'h55;
        chk("mem_ready_empty", bus.mem_ready, 1);
        exp_q.push_back(mk(5'd7, 32'h55));
        step();
        bus.mem_valid = 1'b0;
        chk("mem_no_write_n1", bus.reg_write, 0);
        chk("mem_pend_still", bus.pend_hit_1, 1);
        step();
        chk("mem_write_n2", bus.reg_write, 1);
        chk("mem_write_register", bus.write_register, 7);
        chk("mem_write_data", bus.write_data, 32'h55);
        chk("mem_pend_cleared", bus.pend_hit_1, 0);
        step();
        chk("mem_write_done", bus.reg_write, 0);

        // Fill the FIFO while the ALU owns the port.
        for (int k = 0; k < 4; k++) begin
            bus.alu_valid = 1'b1;
            bus.alu_rd    = ADDR_W'(10 + k);
            bus.alu_data  = DATA_W'(32'hA0 + k);
            bus.mem_valid = 1'b1;
            bus.mem_rd    = ADDR_W'(20 + k);
            bus.mem_data  = DATA_W'(32'hB0 + k);
            exp_q.push_back(mk(ADDR_W'(10 + k), DATA_W'(32'hA0 + k)));
            mem_exp.push_back(mk(ADDR_W'(20 + k), DATA_W'(32'hB0 + k)));
            chk($sformatf("full_ready_%0d", k), bus.mem_ready, 1);
            step();
        end
        chk("full_ready_low", bus.mem_ready, 0);
        bus.alu_rd    = 5'd14;
        bus.alu_data  = 32'hA4;
        bus.mem_rd    = 5'd25;
        bus.mem_data  = 32'hBF;
        exp_q.push_back(mk(5'd14, 32'hA4));
        step();
        chk("full_still_low", bus.mem_ready, 0);
        drive_idle();
        while (mem_exp.size() > 0) exp_q.push_back(mem_exp.pop_front());
        step();
        chk("full_pop0_write", bus.reg_write, 1);
        chk("full_pop0_rd", bus.write_register, 20);
        chk("full_ready_back", bus.mem_ready, 1);
        for (int k = 1; k < 4; k++) begin
            step();
            chk($sformatf("full_pop%0d_rd", k), bus.write_register, 20 + k);
            chk($sformatf("full_pop%0d_data", k), bus.write_data, 32'hB0 + k);
        end
        step();
        chk("full_no_extra", bus.reg_write, 0);

        // Collision on register 9: queued value discarded, ALU value written once.
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd9;
        step();
        bus.iss_valid = 1'b0;
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd9;
        bus.mem_data  = 32'h99;
        step();
        bus.mem_valid    = 1'b0;
        bus.alu_valid    = 1'b1;
        bus.alu_rd       = 5'd9;
        bus.alu_data     = 32'h11;
        bus.pend_query_1 = 5'd9;
        #1;
        chk("coll_pend_set", bus.pend_hit_1, 1);
        exp_q.push_back(mk(5'd9, 32'h11));
        step();
        chk("coll_write", bus.reg_write, 1);
        chk("coll_write_data", bus.write_data, 32'h11);
        chk("coll_pend_cleared", bus.pend_hit_1, 0);
        bus.alu_valid = 1'b0;
        step();
        chk("coll_dropped", bus.reg_write, 0);
        chk("coll_ready", bus.mem_ready, 1);

        // Register 0 is never written nor marked pending.
        drive_idle();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd0;
        bus.alu_data  = 32'hFFFF;
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd0;
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd0;
        bus.mem_data  = 32'h77;
        step();
        drive_idle();
        #1;
        chk("r0_alu_no_write", bus.reg_write, 0);
        chk("r0_hit_1", bus.pend_hit_1, 0);
        chk("r0_hit_2", bus.pend_hit_2, 0);
        step();
        chk("r0_mem_no_write", bus.reg_write, 0);

        // A re-issue to a register retiring in the same edge stays pending.
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd12;
        step();
        bus.iss_valid = 1'b0;
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd12;
        bus.mem_data  = 32'hC12;
        exp_q.push_back(mk(5'd12, 32'hC12));
        step();
        bus.mem_valid    = 1'b0;
        bus.iss_valid    = 1'b1;
        bus.iss_rd       = 5'd12;
        bus.pend_query_2 = 5'd12;
        bus.pend_query_1 = 5'd13;
        step();
        bus.iss_valid = 1'b0;
        chk("setwin_write", bus.reg_write, 1);
        chk("setwin_pend", bus.pend_hit_2, 1);
        chk("setwin_other", bus.pend_hit_1, 0);

        // Reset with three queued entries and pending bits set.
        for (int k = 0; k < 3; k++) begin
            bus.alu_valid = 1'b1;
            bus.alu_rd    = ADDR_W'(1 + k);
            bus.alu_data  = DATA_W'(32'h101 + k);
            bus.mem_valid = 1'b1;
            bus.mem_rd    = (k == 2) ? 5'd8 : ADDR_W'(5 + k);
            bus.mem_data  = DATA_W'(32'h201 + k);
            bus.iss_valid = (k < 2);
            bus.iss_rd    = ADDR_W'(5 + k);
            exp_q.push_back(mk(ADDR_W'(1 + k), DATA_W'(32'h101 + k)));
            step();
        end
        drive_idle();
        @(negedge clk);
        #1;
        bus.pend_query_1 = 5'd5;
        bus.pend_query_2 = 5'd6;
        #1;
        chk("prerst_hit_1", bus.pend_hit_1, 1);
        chk("prerst_hit_2", bus.pend_hit_2, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_reg_write", bus.reg_write, 0);
        chk("midrst_write_register", bus.write_register, 0);
        chk("midrst_write_data", bus.write_data, 0);
        chk("midrst_mem_ready", bus.mem_ready, 1);
        chk("midrst_hit_1", bus.pend_hit_1, 0);
        chk("midrst_hit_2", bus.pend_hit_2, 0);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        chk("postrst_fifo_empty", bus.reg_write, 0);
        chk("postrst_mem_ready", bus.mem_ready, 1);

`ifdef WB_BYPASS_EN
        // Forwarding covers the cycle the bank write is presented.
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd4;
        bus.alu_data  = 32'h44;
        exp_q.push_back(mk(5'd4, 32'h44));
        step();
        bus.alu_valid    = 1'b0;
        bus.pend_query_2 = 5'd4;
        bus.pend_query_1 = 5'd3;
        #1;
        chk("fwd_valid_2", bus.fwd_valid_2, 1);
        chk("fwd_data_2", bus.fwd_data_2, 32'h44);
        chk("fwd_valid_1", bus.fwd_valid_1, 0);
        step();
        chk("fwd_valid_2_gone", bus.fwd_valid_2, 0);
`endif

        drive_idle();
        step();
        step();
        step();
        chk("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
